perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised bank of event counters for the RV32I core's performance monitoring. It replaces fixed per-metric counters with NUM_CH generic channels that add multi-bit increments per cycle. Each channel has selectable wrap or saturate arithmetic, a sticky overflow flag, an atomic snapshot (shadow) bank and a registered read port. It sits inside the core next to the pipeline, gated by the global perf enable, and the testbench dump logic reads it through the read port.

## Interface
- NUM_CH, 8: number of counter channels (1..32)
- CNT_W, 32: counter width in bits (8..64)
- INC_W, 2: per-channel increment width; max increment per cycle is 2^INC_W-1
- SATURATE, 0: 0 = counters wrap modulo 2^CNT_W; 1 = counters clamp at all-ones
- SEL_W, derived: max(1, $clog2(NUM_CH))

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  global count enable; when low, counters hold
- event_inc  in  NUM_CH*INC_W  packed increments; channel i is bits [i*INC_W +: INC_W]
- clear  in  1  synchronous clear of all live counters and overflow flags
- snap  in  1  copy all live counters and flags into the shadow bank
- rd_sel  in  SEL_W  channel to read
- rd_src  in  1  0 = live bank, 1 = shadow bank
- rd_data  out  CNT_W  registered read data
- rd_ovf  out  1  registered overflow flag of the selected channel and bank
- ovf_any  out  1  OR of all live sticky overflow flags (registered)

## Operation
- Reset (rst low, async): all live counters, shadow counters, live and shadow flags, rd_data, rd_ovf and ovf_any go to 0.
- Per channel, each edge, in priority order:
  - clear=1: counter <= 0, flag <= 0. The increment for that cycle is discarded.
  - else if enable=1: sum = counter + inc, computed at CNT_W+1 bits.
    - Wrap mode: counter <= sum[CNT_W-1:0]; flag <= flag | sum[CNT_W].
    - Saturate mode: counter <= sum[CNT_W] ? all-ones : sum[CNT_W-1:0]; flag <= flag | sum[CNT_W].
  - else: hold.
- An increment of 0 never changes a counter or flag.
- snap=1: every shadow counter and flag <= the live value held before this edge. This is atomic across all channels. snap ignores enable.
- snap and clear in the same cycle: the shadow captures the pre-clear values, then the live bank clears.
- Read port:
  - rd_data/rd_ovf <= selected bank[rd_sel], as held before the edge.
  - rd_sel >= NUM_CH returns rd_data=0, rd_ovf=0.
  - Reads have no side effects.
- ovf_any <= OR of the live flags after update. It drops only on clear or reset.

## Timing
- Increment latency: an event_inc value sampled at edge k is visible in the counter after edge k, and on rd_data after edge k+1.
- Read latency: 1 cycle. rd_sel/rd_src sampled at edge k produce rd_data valid after edge k.
- A counter updated at edge k and read at the same edge returns the pre-update value.
- Shadow values are stable from the edge after snap until the next snap or reset. A clear does not affect them.
- ovf_any asserts in the cycle after the overflowing edge.
- rst asserted mid-count zeroes the block immediately, with no clock needed. The first count occurs at the first rising edge after rst deasserts.
- No handshakes: all commands are single-cycle pulses. Holding snap or clear high repeats the action every cycle.

## Test plan
- Reset/idle: assert rst for 3 cycles with random inputs, then release with enable=0 and event_inc=all 3s for 10 cycles -> every channel reads 0, rd_ovf=0, ovf_any=0.
- Counting: enable=1, channel 0 inc=1, channel 3 inc=3 for 100 cycles, then read -> ch0=100, ch3=300, all other channels 0. A read issued on the cycle after the last event shows the final value one edge later.
- Wrap/overflow (CNT_W=8, SATURATE=0): preload ch1 to 254 by counting, then one cycle of inc=3 -> ch1=1, rd_ovf=1, ovf_any=1 the next cycle. Further counting keeps the flag set.
- Saturate (CNT_W=8, SATURATE=1): same stimulus -> ch1=255, flag=1. Additional increments leave ch1 at 255.
- Snapshot with clear: ch2 at 50, pulse snap and clear in the same cycle while inc=2 -> shadow ch2=50, live ch2=0. On the next enabled cycle live ch2=2, shadow still 50.
- Out-of-range read: with NUM_CH=6, set rd_sel=7 -> rd_data=0, rd_ovf=0. Then rd_sel=5 returns channel 5's value after one cycle.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with wrap/saturate arithmetic, sticky overflow and an atomic shadow bank.
// Latency: counters update on the sampling edge; read port and ovf_any are registered (1 cycle).
// Backpressure: none; every input is sampled every cycle and commands are single-cycle pulses.
module perf_counter_bank #(
    parameter int NUM_CH   = 8,
    parameter int CNT_W    = 32,
    parameter int INC_W    = 2,
    parameter int SATURATE = 0,
    parameter int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_CH*INC_W-1:0] event_inc,
    input  logic                    clear,
    input  logic                    snap,
    input  logic [SEL_W-1:0]        rd_sel,
    input  logic                    rd_src,
    output logic [CNT_W-1:0]        rd_data,
    output logic                    rd_ovf,
    output logic                    ovf_any
);

    logic [CNT_W-1:0]  live_cnt [NUM_CH];
    logic [CNT_W-1:0]  shd_cnt  [NUM_CH];
    logic [NUM_CH-1:0] live_ovf;
    logic [NUM_CH-1:0] shd_ovf;
    logic [NUM_CH-1:0] ovf_nxt;

    logic [CNT_W-1:0]  rd_data_nxt;
    logic              rd_ovf_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [INC_W-1:0] inc;
        logic [CNT_W:0]   sum;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_nxt;
        logic             ovf_q;
        logic [CNT_W-1:0] shd_cnt_q;
        logic             shd_ovf_q;

        assign inc = event_inc[i*INC_W +: INC_W];
        // One extra bit keeps the carry out, which is both the overflow flag and the clamp select.
        assign sum = {1'b0, cnt_q} + (CNT_W+1)'(inc);

        always_comb begin
            cnt_nxt    = cnt_q;
            ovf_nxt[i] = ovf_q;
            if (clear) begin
                cnt_nxt    = '0;
                ovf_nxt[i] = 1'b0;
            end else if (enable) begin
                if ((SATURATE != 0) && sum[CNT_W]) begin
                    cnt_nxt = '1;
                end else begin
                    cnt_nxt = sum[CNT_W-1:0];
                end
                ovf_nxt[i] = ovf_q | sum[CNT_W];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_nxt;
                ovf_q <= ovf_nxt[i];
            end
        end

        // Shadow samples the pre-edge live state, so snap+clear captures the values being cleared.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                shd_cnt_q <= '0;
                shd_ovf_q <= 1'b0;
            end else if (snap) begin
                shd_cnt_q <= cnt_q;
                shd_ovf_q <= ovf_q;
            end
        end

        assign live_cnt[i] = cnt_q;
        assign live_ovf[i] = ovf_q;
        assign shd_cnt[i]  = shd_cnt_q;
        assign shd_ovf[i]  = shd_ovf_q;
    end

    // Selects that match no channel fall through to zero.
    always_comb begin
        rd_data_nxt = '0;
        rd_ovf_nxt  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data_nxt = rd_src ? shd_cnt[i] : live_cnt[i];
                rd_ovf_nxt  = rd_src ? shd_ovf[i] : live_ovf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
            rd_ovf  <= 1'b0;
            ovf_any <= 1'b0;
        end else begin
            rd_data <= rd_data_nxt;
            rd_ovf  <= rd_ovf_nxt;
            ovf_any <= |ovf_nxt;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: three configurations (32b wrap x8, 8b wrap x6, 8b saturate x6) share stimulus
// and are checked every cycle against a reference model through a scoreboard queue.
module tb_perf_counter_bank;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        enable;
    logic        clear;
    logic        snap;
    logic        rd_src;
    logic [2:0]  rd_sel;
    logic [1:0]  inc [8];
    logic [15:0] ev;

    always_comb begin
        ev = '0;
        for (int i = 0; i < 8; i++) ev[i*2 +: 2] = inc[i];
    end

    logic [31:0] d0;
    logic [7:0]  d1, d2;
    logic        o0, o1, o2, a0, a1, a2;

    perf_counter_bank #(.NUM_CH(8), .CNT_W(32), .INC_W(2), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .event_inc(ev), .clear(clear), .snap(snap),
        .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(d0), .rd_ovf(o0), .ovf_any(a0));

    perf_counter_bank #(.NUM_CH(6), .CNT_W(8), .INC_W(2), .SATURATE(0)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .event_inc(ev[11:0]), .clear(clear), .snap(snap),
        .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(d1), .rd_ovf(o1), .ovf_any(a1));

    perf_counter_bank #(.NUM_CH(6), .CNT_W(8), .INC_W(2), .SATURATE(1)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .event_inc(ev[11:0]), .clear(clear), .snap(snap),
        .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(d2), .rd_ovf(o2), .ovf_any(a2));

    typedef struct packed {
        logic [31:0] d0;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [2:0]  ro;
        logic [2:0]  any;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] m_cnt [3][8];
    logic        m_ovf [3][8];
    logic [63:0] s_cnt [3][8];
    logic        s_ovf [3][8];

    int    tests_run    = 0;
    int    tests_failed = 0;
    string phase        = "init";

    function automatic int nch(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    function automatic int cwf(input int k);
        return (k == 0) ? 32 : 8;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 8; c++) begin
                m_cnt[k][c] = '0; m_ovf[k][c] = 1'b0;
                s_cnt[k][c] = '0; s_ovf[k][c] = 1'b0;
            end
    endtask

    // Computes what the DUTs will show after the coming edge and advances the model across it.
    task automatic push_expect();
        exp_t        e;
        logic [63:0] rdv [3];
        logic        rov [3];
        logic        anyv [3];
        logic [63:0] mask, s;
        for (int k = 0; k < 3; k++) begin
            rdv[k] = '0;
            rov[k] = 1'b0;
            if (int'(rd_sel) < nch(k)) begin
                rdv[k] = rd_src ? s_cnt[k][rd_sel] : m_cnt[k][rd_sel];
                rov[k] = rd_src ? s_ovf[k][rd_sel] : m_ovf[k][rd_sel];
            end
        end
        if (snap)
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < 8; c++) begin
                    s_cnt[k][c] = m_cnt[k][c];
                    s_ovf[k][c] = m_ovf[k][c];
                end
        for (int k = 0; k < 3; k++) begin
            mask    = (64'd1 << cwf(k)) - 64'd1;
            anyv[k] = 1'b0;
            for (int c = 0; c < nch(k); c++) begin
                if (clear) begin
                    m_cnt[k][c] = '0;
                    m_ovf[k][c] = 1'b0;
                end else if (enable) begin
                    s = m_cnt[k][c] + 64'(inc[c]);
                    if (s > mask) begin
                        m_ovf[k][c] = 1'b1;
                        m_cnt[k][c] = (k == 2) ? mask : (s & mask);
                    end else begin
                        m_cnt[k][c] = s;
                    end
                end
                anyv[k] = anyv[k] | m_ovf[k][c];
            end
        end
        e.d0  = rdv[0][31:0];
        e.d1  = rdv[1][7:0];
        e.d2  = rdv[2][7:0];
        e.ro  = {rov[2], rov[1], rov[0]};
        e.any = {anyv[2], anyv[1], anyv[0]};
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        push_expect();
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("rd_data0", 64'(d0), 64'(e.d0));
            chk("rd_data1", 64'(d1), 64'(e.d1));
            chk("rd_data2", 64'(d2), 64'(e.d2));
            chk("rd_ovf0",  64'(o0), 64'(e.ro[0]));
            chk("rd_ovf1",  64'(o1), 64'(e.ro[1]));
            chk("rd_ovf2",  64'(o2), 64'(e.ro[2]));
            chk("ovf_any0", 64'(a0), 64'(e.any[0]));
            chk("ovf_any1", 64'(a1), 64'(e.any[1]));
            chk("ovf_any2", 64'(a2), 64'(e.any[2]));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_d0"}, 64'(d0), 64'd0);
        chk({tag, "_d1"}, 64'(d1), 64'd0);
        chk({tag, "_d2"}, 64'(d2), 64'd0);
        chk({tag, "_ovf"}, 64'({o2, o1, o0}), 64'd0);
        chk({tag, "_any"}, 64'({a2, a1, a0}), 64'd0);
    endtask

    task automatic set_inc_all(input logic [1:0] v);
        for (int i = 0; i < 8; i++) inc[i] = v;
    endtask

    task automatic randomize_inputs();
        enable = 1'($urandom);
        clear  = 1'($urandom);
        snap   = 1'($urandom);
        rd_src = 1'($urandom);
        rd_sel = 3'($urandom);
        for (int i = 0; i < 8; i++) inc[i] = 2'($urandom);
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0; clear = 1'b0; snap = 1'b0; rd_src = 1'b0; rd_sel = '0;
        set_inc_all(2'd0);
        model_reset();

        phase = "reset";
        repeat (3) begin
            randomize_inputs();
            @(posedge clk);
            @(negedge clk);
            chk_all_zero("in_reset");
        end

        phase = "idle";
        enable = 1'b0; clear = 1'b0; snap = 1'b0;
        set_inc_all(2'd3);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd_sel = 3'(i);
            rd_src = 1'(i / 8);
            step();
        end
        chk_all_zero("idle_end");

        phase = "count";
        set_inc_all(2'd0);
        enable = 1'b1;
        inc[0] = 2'd1;
        inc[3] = 2'd3;
        for (int i = 0; i < 100; i++) begin
            rd_sel = 3'(i);
            rd_src = 1'b0;
            step();
        end
        enable = 1'b0;
        set_inc_all(2'd0);
        for (int i = 0; i < 16; i++) begin
            rd_sel = 3'(i);
            rd_src = 1'(i / 8);
            step();
        end
        rd_sel = 3'd0; rd_src = 1'b0;
        step();
        chk("ch0_total_32b", 64'(d0), 64'd100);
        chk("ch0_total_8b",  64'(d1), 64'd100);
        rd_sel = 3'd3;
        step();
        chk("ch3_total_32b",  64'(d0), 64'd300);
        chk("ch3_wrap_8b",    64'(d1), 64'd44);
        chk("ch3_sat_8b",     64'(d2), 64'd255);
        chk("ch3_ovf_flags",  64'({o2, o1, o0}), 64'b110);

        phase = "wrap";
        clear = 1'b1; enable = 1'b1;
        step();
        clear = 1'b0;
        inc[1] = 2'd2;
        rd_sel = 3'd1;
        for (int i = 0; i < 127; i++) step();
        inc[1] = 2'd3;
        step();
        chk("ch1_pre_254", 64'(d1), 64'd254);
        inc[1] = 2'd0;
        step();
        chk("ch1_wrap_val",  64'(d1), 64'd1);
        chk("ch1_wrap_ovf",  64'(o1), 64'd1);
        chk("ch1_wrap_any",  64'(a1), 64'd1);
        chk("ch1_sat_val",   64'(d2), 64'd255);
        chk("ch1_sat_ovf",   64'(o2), 64'd1);
        chk("ch1_32b_val",   64'(d0), 64'd257);
        chk("ch1_32b_ovf",   64'(o0), 64'd0);
        inc[1] = 2'd3;
        for (int i = 0; i < 6; i++) step();
        inc[1] = 2'd0;
        step();
        chk("ch1_sat_hold",  64'(d2), 64'd255);
        chk("ch1_ovf_kept",  64'({o2, o1}), 64'b11);

        phase = "snap_clear";
        clear = 1'b1;
        step();
        clear = 1'b0;
        inc[2] = 2'd2;
        rd_sel = 3'd2; rd_src = 1'b0;
        for (int i = 0; i < 25; i++) step();
        snap = 1'b1; clear = 1'b1;
        step();
        snap = 1'b0; clear = 1'b0;
        rd_src = 1'b1;
        step();
        chk("ch2_shadow", 64'(d1), 64'd50);
        inc[2] = 2'd0;
        rd_src = 1'b0;
        step();
        chk("ch2_live_after", 64'(d1), 64'd2);
        rd_src = 1'b1;
        step();
        chk("ch2_shadow_stable", 64'(d2), 64'd50);

        phase = "out_of_range";
        inc[5] = 2'd1;
        inc[1] = 2'd3;
        rd_sel = 3'd7; rd_src = 1'b0;
        for (int i = 0; i < 7; i++) step();
        inc[5] = 2'd0;
        inc[1] = 2'd0;
        step();
        chk("sel7_data", 64'(d1), 64'd0);
        chk("sel7_ovf",  64'(o1), 64'd0);
        rd_sel = 3'd6; rd_src = 1'b1;
        step();
        rd_sel = 3'd5; rd_src = 1'b0;
        step();
        chk("sel5_data", 64'(d1), 64'd7);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(3) != 0);
            clear  = ($urandom_range(39) == 0);
            snap   = ($urandom_range(14) == 0);
            rd_src = 1'($urandom);
            rd_sel = 3'($urandom);
            for (int c = 0; c < 8; c++) inc[c] = 2'($urandom);
            step();
        end

        phase = "async_reset";
        enable = 1'b1; set_inc_all(2'd3); rd_sel = 3'd1; rd_src = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rd_sel = 3'(i);
            rd_src = 1'(i / 8);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
